// File: rtl/axi4_protocol_checker.sv
// rtl/axi4_protocol_checker.sv - passive AXI4 protocol checker with sticky error reporting

// Burst-length FIFO; holds the len field of each accepted address until its last data beat.
module axi4_len_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    assign do_push = push && (!full || do_pop);

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module axi4_protocol_checker #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ERR_CNT_WIDTH   = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic [7:0]               awlen,
    input  logic [2:0]               awsize,
    input  logic [1:0]               awburst,
    input  logic                     awvalid,
    input  logic                     awready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [DATA_WIDTH/8-1:0]  wstrb,
    input  logic                     wlast,
    input  logic                     wvalid,
    input  logic                     wready,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic [7:0]               arlen,
    input  logic [2:0]               arsize,
    input  logic [1:0]               arburst,
    input  logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    input  logic                     rready,
    output logic [11:0]              err_vec,
    output logic                     err_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [3:0]               first_err,
    input  logic                     err_clear
);
    localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int AXW = ADDR_WIDTH + 13;
    localparam int WW  = DATA_WIDTH + DATA_WIDTH/8 + 1;
    localparam int RW  = DATA_WIDTH + 3;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [7:0] aw_head, ar_head;
    logic aw_empty, aw_full, ar_empty, ar_full;
    logic w_pop, r_pop, b_dec;
    logic [8:0] wbeat, rbeat;
    logic [CW-1:0] pend_b;
    logic first_edge;

    logic [AXW-1:0] aw_pl, aw_sh, ar_pl, ar_sh;
    logic [WW-1:0]  w_pl, w_sh;
    logic [RW-1:0]  r_pl, r_sh;
    logic [1:0]     b_sh;
    logic aw_st, w_st, b_st, ar_st, r_st;

    logic [11:0] errs;
    logic [3:0]  low_idx;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // The checker resyncs on LAST: a burst retires on its LAST beat, early or late.
    assign w_pop = w_hs && wlast && !aw_empty;
    assign r_pop = r_hs && rlast && !ar_empty;
    assign b_dec = b_hs && (pend_b != '0);

    assign aw_pl = {awaddr, awlen, awsize, awburst};
    assign ar_pl = {araddr, arlen, arsize, arburst};
    assign w_pl  = {wdata, wstrb, wlast};
    assign r_pl  = {rdata, rresp, rlast};

    axi4_len_queue #(.DEPTH(MAX_OUTSTANDING)) u_aw_q (
        .clk(aclk), .rst_n(aresetn), .push(aw_hs), .pop(w_pop), .din(awlen),
        .head(aw_head), .empty(aw_empty), .full(aw_full)
    );

    axi4_len_queue #(.DEPTH(MAX_OUTSTANDING)) u_ar_q (
        .clk(aclk), .rst_n(aresetn), .push(ar_hs), .pop(r_pop), .din(arlen),
        .head(ar_head), .empty(ar_empty), .full(ar_full)
    );

    // Violations sampled at this edge.
    always_comb begin
        errs     = '0;
        errs[0]  = aw_st && (!awvalid || aw_pl != aw_sh);
        errs[1]  = w_st  && (!wvalid  || w_pl  != w_sh);
        errs[2]  = b_st  && (!bvalid  || bresp != b_sh);
        errs[3]  = ar_st && (!arvalid || ar_pl != ar_sh);
        errs[4]  = r_st  && (!rvalid  || r_pl  != r_sh);
        errs[5]  = w_hs && !aw_empty && (wlast != (wbeat == {1'b0, aw_head}));
        errs[6]  = r_hs && !ar_empty && (rlast != (rbeat == {1'b0, ar_head}));
        errs[7]  = w_hs && aw_empty;
        errs[8]  = bvalid && (pend_b == '0);
        errs[9]  = rvalid && ar_empty;
        errs[10] = (aw_hs && aw_full && !w_pop) || (ar_hs && ar_full && !r_pop);
        errs[11] = first_edge && (awvalid || wvalid || arvalid);
    end

    // Lowest set bit of this cycle's violations, for the first-error code.
    always_comb begin
        low_idx = '0;
        for (int i = 11; i >= 0; i--) begin
            if (errs[i]) low_idx = 4'(i);
        end
    end

    // Beat counters, pending-B counter and stall shadows.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wbeat      <= '0;
            rbeat      <= '0;
            pend_b     <= '0;
            first_edge <= 1'b1;
            aw_st <= 1'b0; w_st <= 1'b0; b_st <= 1'b0; ar_st <= 1'b0; r_st <= 1'b0;
            aw_sh <= '0;   w_sh <= '0;   b_sh <= '0;   ar_sh <= '0;   r_sh <= '0;
        end else begin
            first_edge <= 1'b0;
            if (w_hs && !aw_empty) wbeat <= wlast ? 9'd0 : wbeat + 9'd1;
            if (r_hs && !ar_empty) rbeat <= rlast ? 9'd0 : rbeat + 9'd1;
            if (w_pop && !b_dec && pend_b != CW'(MAX_OUTSTANDING)) pend_b <= pend_b + 1'b1;
            else if (b_dec && !w_pop)                              pend_b <= pend_b - 1'b1;
            aw_st <= awvalid && !awready;
            w_st  <= wvalid  && !wready;
            b_st  <= bvalid  && !bready;
            ar_st <= arvalid && !arready;
            r_st  <= rvalid  && !rready;
            if (awvalid && !awready) aw_sh <= aw_pl;
            if (wvalid  && !wready)  w_sh  <= w_pl;
            if (bvalid  && !bready)  b_sh  <= bresp;
            if (arvalid && !arready) ar_sh <= ar_pl;
            if (rvalid  && !rready)  r_sh  <= r_pl;
        end
    end

    // Sticky error reporting; a clear wins over a violation in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_vec   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            first_err <= '0;
        end else if (err_clear) begin
            err_vec   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            first_err <= '0;
        end else begin
            err_pulse <= (errs != '0);
            if (errs != '0) begin
                err_vec <= err_vec | errs;
                if (err_vec == '0)     first_err <= low_idx;
                if (err_count != '1)   err_count <= err_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi4_protocol_checker.sv
// tb/tb_axi4_protocol_checker.sv - randomized self-checking bench for axi4_protocol_checker
module tb_axi4_protocol_checker;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int MO   = 4;
    localparam int ECW  = 4;
    localparam int CMAX = (1 << ECW) - 1;

    logic aclk;
    logic aresetn;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rready, rlast;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [11:0] err_vec;
    logic err_pulse;
    logic [ECW-1:0] err_count;
    logic [3:0] first_err;
    logic err_clear;

    axi4_protocol_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO),
                            .ERR_CNT_WIDTH(ECW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err_vec(err_vec), .err_pulse(err_pulse), .err_count(err_count),
        .first_err(first_err), .err_clear(err_clear)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Reference model state: outstanding burst lengths as queues, plain counters.
    int awq[$];
    int arq[$];
    int m_wbeat, m_rbeat, m_pend;
    bit m_first;
    bit m_aw_st, m_w_st, m_b_st, m_ar_st, m_r_st;
    logic [AW+12:0] m_aw_sh, m_ar_sh;
    logic [DW+DW/8:0] m_w_sh;
    logic [DW+2:0] m_r_sh;
    logic [1:0] m_b_sh;
    logic [11:0] x_vec;
    int x_cnt;
    logic [3:0] x_first;
    logic x_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [11:0] e);
        for (int i = 0; i < 12; i++) if (e[i]) return 4'(i);
        return 4'd0;
    endfunction

    task automatic model_reset();
        awq.delete(); arq.delete();
        m_wbeat = 0; m_rbeat = 0; m_pend = 0; m_first = 1;
        m_aw_st = 0; m_w_st = 0; m_b_st = 0; m_ar_st = 0; m_r_st = 0;
        x_vec = '0; x_cnt = 0; x_first = '0; x_pulse = 1'b0;
    endtask

    // Evaluate the protocol rules against the inputs about to be sampled.
    task automatic model_edge();
        logic [11:0] e;
        bit w_pop, r_pop, dec;
        int aw_n, ar_n;
        e = '0; w_pop = 0; r_pop = 0;
        aw_n = awq.size(); ar_n = arq.size();
        if (m_aw_st && (!awvalid || {awaddr, awlen, awsize, awburst} != m_aw_sh)) e[0] = 1;
        if (m_w_st  && (!wvalid  || {wdata, wstrb, wlast} != m_w_sh))              e[1] = 1;
        if (m_b_st  && (!bvalid  || bresp != m_b_sh))                              e[2] = 1;
        if (m_ar_st && (!arvalid || {araddr, arlen, arsize, arburst} != m_ar_sh)) e[3] = 1;
        if (m_r_st  && (!rvalid  || {rdata, rresp, rlast} != m_r_sh))              e[4] = 1;
        if (wvalid && wready) begin
            if (aw_n == 0) e[7] = 1;
            else begin
                if (wlast != (m_wbeat + 1 == awq[0] + 1)) e[5] = 1;
                if (wlast) begin void'(awq.pop_front()); m_wbeat = 0; w_pop = 1; end
                else m_wbeat++;
            end
        end
        if (rvalid && ar_n == 0) e[9] = 1;
        if (rvalid && rready && ar_n != 0) begin
            if (rlast != (m_rbeat + 1 == arq[0] + 1)) e[6] = 1;
            if (rlast) begin void'(arq.pop_front()); m_rbeat = 0; r_pop = 1; end
            else m_rbeat++;
        end
        if (awvalid && awready) begin
            if (aw_n == MO && !w_pop) e[10] = 1;
            else awq.push_back(int'(awlen));
        end
        if (arvalid && arready) begin
            if (ar_n == MO && !r_pop) e[10] = 1;
            else arq.push_back(int'(arlen));
        end
        if (bvalid && m_pend == 0) e[8] = 1;
        dec = bvalid && bready && m_pend > 0;
        m_pend = m_pend + int'(w_pop) - int'(dec);
        if (m_pend > MO) m_pend = MO;
        if (m_first && (awvalid || wvalid || arvalid)) e[11] = 1;
        m_first = 0;
        m_aw_st = awvalid && !awready; if (m_aw_st) m_aw_sh = {awaddr, awlen, awsize, awburst};
        m_w_st  = wvalid && !wready;   if (m_w_st)  m_w_sh  = {wdata, wstrb, wlast};
        m_b_st  = bvalid && !bready;   if (m_b_st)  m_b_sh  = bresp;
        m_ar_st = arvalid && !arready; if (m_ar_st) m_ar_sh = {araddr, arlen, arsize, arburst};
        m_r_st  = rvalid && !rready;   if (m_r_st)  m_r_sh  = {rdata, rresp, rlast};
        if (err_clear) begin
            x_vec = '0; x_cnt = 0; x_first = '0; x_pulse = 1'b0;
        end else begin
            x_pulse = (e != '0);
            if (e != '0) begin
                if (x_vec == '0) x_first = lowest(e);
                x_vec |= e;
                if (x_cnt < CMAX) x_cnt++;
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge aclk);
        @(negedge aclk);
        check("vec", 32'(err_vec), 32'(x_vec));
        check("cnt", 32'(err_count), 32'(x_cnt));
        check("first", 32'(first_err), 32'(x_first));
        check("pulse", 32'(err_pulse), 32'(x_pulse));
    endtask

    task automatic idle();
        awvalid = 0; wvalid = 0; bvalid = 0; arvalid = 0; rvalid = 0; err_clear = 0;
        awready = 1; wready = 1; bready = 1; arready = 1; rready = 1;
        awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'd1;
        araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'd1;
        wdata = '0; wstrb = '1; wlast = 0; bresp = '0; rdata = '0; rresp = '0; rlast = 0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 0;
        idle();
        #1;
        check("rst_vec", 32'(err_vec), 32'd0);
        check("rst_cnt", 32'(err_count), 32'd0);
        check("rst_first", 32'(first_err), 32'd0);
        check("rst_pulse", 32'(err_pulse), 32'd0);
        model_reset();
        repeat (2) @(negedge aclk);
        aresetn = 1;
    endtask

    task automatic aw_beat(input int len);
        awvalid = 1; awready = 1; awlen = 8'(len); awaddr = $urandom; cyc(); awvalid = 0;
    endtask
    task automatic w_beat(input logic last);
        wvalid = 1; wready = 1; wlast = last; wdata = {$urandom, $urandom}; cyc(); wvalid = 0;
    endtask
    task automatic b_beat();
        bvalid = 1; bready = 1; cyc(); bvalid = 0;
    endtask
    task automatic ar_beat(input int len);
        arvalid = 1; arready = 1; arlen = 8'(len); araddr = $urandom; cyc(); arvalid = 0;
    endtask
    task automatic r_beat(input logic last);
        rvalid = 1; rready = 1; rlast = last; rdata = {$urandom, $urandom}; cyc(); rvalid = 0;
    endtask
    task automatic clr();
        err_clear = 1; cyc(); err_clear = 0;
    endtask

    // Mostly-legal random traffic: payload held while stalled, occasional rule breaks.
    task automatic rand_cycle();
        if (!(m_aw_st && $urandom_range(9) != 0)) begin
            awvalid = ($urandom_range(3) == 0); awaddr = $urandom; awlen = 8'($urandom_range(3));
            awsize = 3'($urandom); awburst = 2'($urandom);
        end
        awready = 1'($urandom_range(1));
        if (!(m_w_st && $urandom_range(9) != 0)) begin
            wvalid = (awq.size() != 0) ? 1'($urandom_range(1)) : ($urandom_range(15) == 0);
            wdata = {$urandom, $urandom}; wstrb = 8'($urandom);
            wlast = (awq.size() != 0) ? ((m_wbeat == awq[0]) ^ ($urandom_range(15) == 0))
                                      : 1'($urandom_range(1));
        end
        wready = 1'($urandom_range(1));
        if (!(m_b_st && $urandom_range(9) != 0)) begin
            bvalid = (m_pend > 0) ? 1'($urandom_range(1)) : ($urandom_range(15) == 0);
            bresp = 2'($urandom);
        end
        bready = 1'($urandom_range(1));
        if (!(m_ar_st && $urandom_range(9) != 0)) begin
            arvalid = ($urandom_range(3) == 0); araddr = $urandom; arlen = 8'($urandom_range(3));
            arsize = 3'($urandom); arburst = 2'($urandom);
        end
        arready = 1'($urandom_range(1));
        if (!(m_r_st && $urandom_range(9) != 0)) begin
            rvalid = (arq.size() != 0) ? 1'($urandom_range(1)) : ($urandom_range(15) == 0);
            rdata = {$urandom, $urandom}; rresp = 2'($urandom);
            rlast = (arq.size() != 0) ? ((m_rbeat == arq[0]) ^ ($urandom_range(15) == 0))
                                      : 1'($urandom_range(1));
        end
        rready = 1'($urandom_range(1));
        err_clear = ($urandom_range(39) == 0);
    endtask

    initial begin
        aresetn = 0;
        idle();
        model_reset();
        do_reset();

        // Legal write and read bursts.
        cyc();
        aw_beat(3); w_beat(0); w_beat(0); w_beat(0); w_beat(1); b_beat();
        ar_beat(0); r_beat(1); cyc();
        check("t1_vec", 32'(err_vec), 32'h0);
        check("t1_cnt", 32'(err_count), 32'h0);

        // Early WLAST, then a clean single-beat burst.
        aw_beat(3); w_beat(0); w_beat(1);
        check("t2_vec", 32'(err_vec), 32'h20);
        check("t2_first", 32'(first_err), 32'd5);
        check("t2_pulse", 32'(err_pulse), 32'd1);
        cyc();
        check("t2_pulse_off", 32'(err_pulse), 32'd0);
        aw_beat(0); w_beat(1);
        check("t2_no_more", 32'(err_count), 32'd1);
        b_beat(); b_beat();

        // AW payload change while stalled.
        clr();
        awvalid = 1; awready = 0; awlen = 0; awaddr = 32'h100; cyc();
        awaddr = 32'h104; cyc(); cyc();
        awready = 1; cyc(); awvalid = 0;
        check("t3_vec", 32'(err_vec), 32'h1);
        check("t3_cnt", 32'(err_count), 32'd1);
        w_beat(1); b_beat();

        // AR overflow, drain, then R with empty queue.
        clr();
        for (int i = 0; i < 5; i++) ar_beat(0);
        check("t4_ovf", 32'(err_vec), 32'h400);
        for (int i = 0; i < 4; i++) r_beat(1);
        check("t4_drain", 32'(err_vec), 32'h400);
        r_beat(1);
        check("t4_rempty", 32'(err_vec), 32'h600);

        // Unexpected B, then clear.
        clr();
        b_beat();
        check("t5_vec", 32'(err_vec), 32'h100);
        check("t5_first", 32'(first_err), 32'd8);
        clr();
        check("t5_clr_vec", 32'(err_vec), 32'h0);
        check("t5_clr_cnt", 32'(err_count), 32'h0);
        check("t5_clr_first", 32'(first_err), 32'h0);

        // Reset mid-burst, then a fresh burst.
        b_beat();
        aw_beat(7); w_beat(0); w_beat(0); w_beat(0);
        do_reset();
        cyc();
        aw_beat(1); w_beat(0); w_beat(1); b_beat();
        check("t6_vec", 32'(err_vec), 32'h0);
        check("t6_cnt", 32'(err_count), 32'h0);

        // Valid asserted on the first edge after reset release.
        do_reset();
        awvalid = 1; awready = 1; awlen = 0; cyc(); awvalid = 0;
        check("t7_vec", 32'(err_vec), 32'h800);
        check("t7_first", 32'(first_err), 32'd11);
        w_beat(1); b_beat(); clr();

        // Randomized traffic against the model.
        repeat (3000) begin
            rand_cycle();
            cyc();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_protocol_checker.md
Name: axi4_protocol_checker

Overview:
- Synthesizable, parametrised AXI4 protocol checker. It is the successor to the VIP's simulation-only assertion module.
- Passively observes all five channels of one AXI4 interface: AW, W, B, AR, R.
- Tracks outstanding bursts in internal length queues and checks beat counts, LAST placement, response ordering and payload stability.
- Reports violations as sticky error bits, a one-cycle pulse, a saturating counter and a first-error code. Instantiated beside the DUT in the env, and usable in emulation.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr
- DATA_WIDTH, 64, width of wdata/rdata; must be a power of 2, 8..1024
- MAX_OUTSTANDING, 4, depth of each of the AW and AR length queues; power of 2, 2..16
- ERR_CNT_WIDTH, 16, width of err_count

Ports:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- awaddr  in  ADDR_WIDTH
- awlen  in  8
- awsize  in  3
- awburst  in  2
- awvalid  in  1
- awready  in  1
- wdata  in  DATA_WIDTH
- wstrb  in  DATA_WIDTH/8
- wlast  in  1
- wvalid  in  1
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  in  1
- araddr  in  ADDR_WIDTH
- arlen  in  8
- arsize  in  3
- arburst  in  2
- arvalid  in  1
- arready  in  1
- rdata  in  DATA_WIDTH
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  in  1
- err_vec  out  12  sticky error flags, bit meanings below
- err_pulse  out  1  high for one cycle after any new violation
- err_count  out  ERR_CNT_WIDTH  number of violating cycles, saturating
- first_err  out  4  index of the lowest err_vec bit set in the first violating cycle
- err_clear  in  1  synchronous clear of err_vec, err_count and first_err

Behaviour:
- Reset: aresetn is asynchronous and active-low. While low, all outputs are 0, queues are empty, and all counters and shadow registers are cleared. A reset mid-burst discards all tracking state.
- Handshake definition: a channel handshake occurs at a posedge aclk where valid && ready.
- Stall shadow registers:
  - Each channel keeps a registered payload shadow and a "stalled" flag.
  - stalled is set at any edge with valid && !ready, and cleared on handshake.
  - AW payload = {awaddr, awlen, awsize, awburst}.
  - W payload = {wdata, wstrb, wlast}.
  - AR payload = {araddr, arlen, arsize, arburst}.
  - R payload = {rdata, rresp, rlast}.
  - B payload = bresp.
- Stability and valid-drop checks: at an edge where stalled was set, a payload differing from its shadow, or valid low, flags that channel's error bit.
- err_vec bit map:
  - 0: AW stability/drop
  - 1: W stability/drop
  - 2: B stability/drop
  - 3: AR stability/drop
  - 4: R stability/drop
  - 5: WLAST wrong. Either wlast=1 on a beat other than the expected last, or wlast=0 on the expected last. Expected last is beat == awlen+1 of the queue head.
  - 6: RLAST wrong; same rule as bit 5, against the AR queue head.
  - 7: W handshake while the AW queue is empty. The VIP master never issues write data before its address.
  - 8: bvalid high while the pending-B counter is 0.
  - 9: rvalid high while the AR queue is empty.
  - 10: AW or AR handshake while its queue holds MAX_OUTSTANDING entries. The push is dropped.
  - 11: any of awvalid, wvalid, arvalid high in the first aclk edge after reset release.
- Write tracking:
  - An AW handshake pushes awlen into the AW queue.
  - Each W handshake increments the write beat counter.
  - A W handshake carrying the expected-last beat pops the AW queue, resets the beat counter to 0, and increments pending-B.
  - The checker resyncs on wlast: if wlast arrives early or late, the pop still happens on the wlast beat and bit 5 is flagged.
  - A B handshake decrements pending-B. pending-B saturates at MAX_OUTSTANDING and does not decrement below 0.
- Read tracking: identical to write tracking using the AR queue and R beats. There are no IDs; responses are checked in order.
- Simultaneous events: a push and a pop in the same cycle are both performed, so occupancy is unchanged. A push when full with a simultaneous pop is not an overflow.
- Error outputs:
  - Multiple errors in one cycle set all their bits.
  - err_count increments by 1 per violating cycle and saturates at all-ones.
  - first_err is latched only while err_vec == 0.
  - err_pulse is registered and asserted in the cycle after the edge at which the violation was sampled.
  - err_clear has priority over a new error in the same cycle.
- Latency: all checks are sampled at posedge aclk. Outputs update one cycle later.

Test Plan:
- Legal AW len=3, W 4 beats with wlast on beat 4, B OKAY; AR len=0, R 1 beat with rlast -> err_vec=0, err_count=0, both queues empty at the end.
- AW len=3, wlast asserted on beat 2 -> err_vec[5]=1, first_err=5, err_pulse one cycle. The next AW len=0 with a single wlast beat adds no further error.
- awvalid=1, awready=0 for 3 cycles, awaddr changes 0x100->0x104 in cycle 2 -> err_vec[0]=1, err_count=1.
- MAX_OUTSTANDING=4: 5 AR handshakes with no R traffic -> err_vec[10]=1 on the 5th. Then 4 single-beat R bursts -> no error; a further rvalid -> err_vec[9]=1.
- bvalid asserted before any wlast handshake -> err_vec[8]=1. Then err_clear=1 -> err_vec=0, err_count=0, first_err=0 next cycle.
- Reset asserted mid 8-beat write after beat 3 -> all outputs 0 immediately. After release, a fresh AW len=1 with 2 beats -> no error.
